// File: rtl/branch_predictor_bht.sv
// Branch history table: tagged direct-mapped BTB with per-entry 2-bit
// saturating counters, runtime-selectable strategy, and resolve-stage
// mispredict/redirect/squash generation plus branch statistics.
//
// Ports:
//   clk, rst            rising-edge clock, async active-low reset
//   mode                00 static NT, 01 static T (BTB), 10 delay slot, 11 dynamic
//   if_pc               fetch PC to predict
//   pred_taken          prediction for if_pc
//   pred_target         predicted next PC for if_pc
//   upd_valid           resolved branch present this cycle
//   upd_pc, upd_target  resolved branch PC and actual target
//   upd_taken           actual outcome
//   upd_pred_taken      prediction made for the resolved branch
//   mispredict          resolved branch was mispredicted
//   redirect_pc         correct next PC on mispredict
//   squash_ifid         kill the IF/ID instruction
//   br_count, mp_count  saturating branch / mispredict counters
module branch_predictor_bht #(
    parameter int          ENTRIES  = 16,
    parameter int          PC_W     = 32,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_pred_taken,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic            squash_ifid,
    output logic [15:0]     br_count,
    output logic [15:0]     mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef enum logic [1:0] {
        MODE_NT  = 2'b00,
        MODE_T   = 2'b01,
        MODE_DS  = 2'b10,
        MODE_DYN = 2'b11
    } mode_e;

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        pred_taken = 1'b0;
        case (mode_sel)
            MODE_T:   pred_taken = if_hit;
            MODE_DYN: pred_taken = if_hit && cnt_q[if_idx][1];
            default:  pred_taken = 1'b0;
        endcase
        // Valid bits clear asynchronously, but gate anyway so the
        // outputs are defined during reset regardless of table state.
        if (!rst) begin
            pred_taken = 1'b0;
        end
    end

    assign pred_target = pred_taken ? tgt_q[if_idx]
                                    : if_pc + PC_W'(4);

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_cnt;
    logic             wr_entry;
    logic             wr_cnt;
    logic [1:0]       cnt_next;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_cnt = cnt_q[upd_idx];

    always_comb begin
        wr_entry = 1'b0;
        wr_cnt   = 1'b0;
        cnt_next = upd_cnt;
        if (upd_valid) begin
            case (mode_sel)
                MODE_T: begin
                    wr_entry = upd_taken;
                end
                MODE_DYN: begin
                    if (upd_hit) begin
                        wr_cnt = 1'b1;
                        if (upd_taken) begin
                            wr_entry = 1'b1;
                            cnt_next = (upd_cnt == 2'b11) ? 2'b11
                                                          : upd_cnt + 2'b01;
                        end else begin
                            cnt_next = (upd_cnt == 2'b00) ? 2'b00
                                                          : upd_cnt - 2'b01;
                        end
                    end else if (upd_taken) begin
                        wr_entry = 1'b1;
                        wr_cnt   = 1'b1;
                        cnt_next = 2'b10;
                    end
                end
                default: begin
                    wr_entry = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else begin
            if (wr_entry) begin
                valid_q[upd_idx] <= 1'b1;
            end
            if (wr_cnt) begin
                cnt_q[upd_idx] <= cnt_next;
            end
        end
    end

    // Tag/target payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_entry) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    assign mispredict  = rst && upd_valid && (upd_taken != upd_pred_taken);
    assign squash_ifid = mispredict && (mode_sel != MODE_DS);
    assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (upd_valid && (br_count != 16'hFFFF)) begin
                br_count <= br_count + 16'd1;
            end
            if (mispredict && (mp_count != 16'hFFFF)) begin
                mp_count <= mp_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus
// randomized traffic against a table-of-entries reference model.
module tb_branch_predictor_bht;

    localparam int ENT  = 16;
    localparam int IDXB = $clog2(ENT);

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        squash_ifid;
    logic [15:0] br_count;
    logic [15:0] mp_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ENTRIES(ENT), .PC_W(32), .CNT_INIT(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .squash_ifid(squash_ifid),
        .br_count(br_count), .mp_count(mp_count)
    );

    // Reference model: one record per table slot, counters as integers.
    bit          m_valid [ENT];
    logic [31:0] m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_cnt   [ENT];
    int          m_br;
    int          m_mp;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void model_predict(input logic [1:0] md,
                                          input logic [31:0] pc,
                                          output logic tk,
                                          output logic [31:0] tg);
        int i;
        bit hit;
        i   = int'((pc >> 2) % ENT);
        hit = m_valid[i] && (m_tag[i] == (pc >> (IDXB + 2)));
        if (md == 2'd1)      tk = hit;
        else if (md == 2'd3) tk = hit && (m_cnt[i] >= 2);
        else                 tk = 1'b0;
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [1:0] md,
                                         input logic [31:0] pc,
                                         input logic tk,
                                         input logic [31:0] tg,
                                         input logic pt);
        int i;
        bit hit;
        i   = int'((pc >> 2) % ENT);
        hit = m_valid[i] && (m_tag[i] == (pc >> (IDXB + 2)));
        if ((md == 2'd1 || md == 2'd3) && tk) begin
            m_valid[i] = 1;
            m_tag[i]   = pc >> (IDXB + 2);
            m_tgt[i]   = tg;
        end
        if (md == 2'd3) begin
            if (hit) m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                   : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            else if (tk) m_cnt[i] = 2;
        end
        if (m_br < 65535) m_br++;
        if (tk != pt && m_mp < 65535) m_mp++;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] t;
        case ($urandom % 4)
            0: t = 32'd0;
            1: t = 32'd1;
            2: t = 32'd2;
            default: t = 32'h03FF_FFFF;
        endcase
        return (t << (IDXB + 2)) | (($urandom % ENT) << 2);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        upd_pred_taken = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        mode = 2'b11;
        if_pc = 32'h14;
        upd_valid = 1'b1;
        upd_pc = 32'h14;
        upd_target = 32'h54;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        #2;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h18) begin
            errors++;
            $display("FAIL reset_pred: got %b/%h want 0/00000018",
                     pred_taken, pred_target);
        end
        checks++;
        if (br_count !== 16'd0 || mp_count !== 16'd0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got br=%h mp=%h mp_out=%b want 0/0/0",
                     br_count, mp_count, mispredict);
        end
        @(posedge clk);
        #1;
        checks++;
        if (br_count !== 16'd0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignore_upd: got br=%h pt=%b want 0/0",
                     br_count, pred_taken);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_update(2'b11, 32'h14, 1'b1, 32'h54, 1'b0);
        #1;
        upd_valid = 1'b0;
        #1;
        checks++;
        if (br_count !== 16'd1 || mp_count !== 16'd1 ||
            pred_taken !== 1'b1 || pred_target !== 32'h54) begin
            errors++;
            $display("FAIL first_edge: got br=%h mp=%h pt=%b tg=%h want 1/1/1/54",
                     br_count, mp_count, pred_taken, pred_target);
        end
    endtask

    task automatic test_train();
        do_reset();
        mode = 2'b11;
        if_pc = 32'h14;
        upd_valid = 1'b1;
        upd_pc = 32'h14;
        upd_target = 32'h54;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h54 ||
            squash_ifid !== 1'b1 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL train_resolve: got mp=%b rd=%h sq=%b pt=%b want 1/54/1/0",
                     mispredict, redirect_pc, squash_ifid, pred_taken);
        end
        @(posedge clk);
        model_update(2'b11, 32'h14, 1'b1, 32'h54, 1'b0);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h54 ||
            mispredict !== 1'b0 || squash_ifid !== 1'b0) begin
            errors++;
            $display("FAIL train_lookup: got pt=%b tg=%h mp=%b sq=%b want 1/54/0/0",
                     pred_taken, pred_target, mispredict, squash_ifid);
        end
    endtask

    task automatic test_loop();
        bit outc [6] = '{1, 1, 1, 1, 0, 1};
        int expc [6] = '{2, 3, 3, 3, 2, 3};
        logic        mtk;
        logic [31:0] mtg;
        do_reset();
        mode = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if_pc = 32'h20;
            model_predict(2'b11, 32'h20, mtk, mtg);
            upd_valid = 1'b1;
            upd_pc = 32'h20;
            upd_target = 32'h08;
            upd_taken = outc[k];
            upd_pred_taken = mtk;
            @(negedge clk);
            checks++;
            if (pred_taken !== mtk || mispredict !== (outc[k] != mtk)) begin
                errors++;
                $display("FAIL loop_pred[%0d]: got pt=%b mp=%b want %b/%b",
                         k, pred_taken, mispredict, mtk, outc[k] != mtk);
            end
            @(posedge clk);
            model_update(2'b11, 32'h20, outc[k], 32'h08, mtk);
            #1;
            checks++;
            if (int'(dut.cnt_q[8]) !== expc[k]) begin
                errors++;
                $display("FAIL loop_cnt[%0d]: got %0d want %0d",
                         k, dut.cnt_q[8], expc[k]);
            end
        end
        upd_valid = 1'b0;
        #1;
        checks++;
        if (mp_count !== 16'd2 || br_count !== 16'd6) begin
            errors++;
            $display("FAIL loop_stats: got mp=%0d br=%0d want 2/6",
                     mp_count, br_count);
        end
    endtask

    task automatic test_delay_slot();
        do_reset();
        mode = 2'b10;
        if_pc = 32'h3C;
        upd_valid = 1'b1;
        upd_pc = 32'h3C;
        upd_target = 32'h10;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (mispredict !== 1'b1 || squash_ifid !== 1'b0 ||
            redirect_pc !== 32'h10 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL delay_slot: got mp=%b sq=%b rd=%h pt=%b want 1/0/10/0",
                     mispredict, squash_ifid, redirect_pc, pred_taken);
        end
        @(posedge clk);
        #1;
        mode = 2'b00;
        upd_taken = 1'b0;
        upd_pred_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (mispredict !== 1'b1 || squash_ifid !== 1'b1 ||
            redirect_pc !== 32'h40) begin
            errors++;
            $display("FAIL static_nt_resolve: got mp=%b sq=%b rd=%h want 1/1/40",
                     mispredict, squash_ifid, redirect_pc);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        mode = 2'b01;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h40) begin
            errors++;
            $display("FAIL no_write_ds: got pt=%b tg=%h want 0/40",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        do_reset();
        mode = 2'b11;
        if_pc = 32'h0;
        upd_valid = 1'b1;
        upd_pc = 32'h14;
        upd_target = 32'h54;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        if_pc = 32'h54;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h58) begin
            errors++;
            $display("FAIL alias_miss: got pt=%b tg=%h want 0/58",
                     pred_taken, pred_target);
        end
        if_pc = 32'h14;
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        upd_pred_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h54) begin
            errors++;
            $display("FAIL read_before_write: got pt=%b tg=%h want 1/54",
                     pred_taken, pred_target);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL alias_decrement: got pt=%b want 0", pred_taken);
        end
        mode = 2'b01;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h54) begin
            errors++;
            $display("FAIL mode_retain: got pt=%b tg=%h want 1/54",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        logic        mtk;
        logic [31:0] mtg;
        logic [31:0] r;
        logic        exp_mp;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mode = 2'($urandom % 4);
            if_pc = rand_pc();
            upd_valid = ($urandom % 4) != 0;
            upd_pc = rand_pc();
            r = $urandom;
            upd_target = r & 32'hFFFF_FFFC;
            upd_taken = 1'($urandom % 2);
            upd_pred_taken = 1'($urandom % 2);
            model_predict(mode, if_pc, mtk, mtg);
            exp_mp = upd_valid && (upd_taken != upd_pred_taken);
            @(negedge clk);
            checks++;
            if (pred_taken !== mtk || pred_target !== mtg) begin
                errors++;
                $display("FAIL rand_pred[%0d]: got %b/%h want %b/%h",
                         n, pred_taken, pred_target, mtk, mtg);
            end
            checks++;
            if (mispredict !== exp_mp ||
                squash_ifid !== (exp_mp && mode != 2'b10)) begin
                errors++;
                $display("FAIL rand_resolve[%0d]: got mp=%b sq=%b want %b/%b",
                         n, mispredict, squash_ifid, exp_mp,
                         exp_mp && mode != 2'b10);
            end
            if (upd_valid) begin
                checks++;
                if (redirect_pc !== (upd_taken ? upd_target : upd_pc + 32'd4)) begin
                    errors++;
                    $display("FAIL rand_redirect[%0d]: got %h want %h", n,
                             redirect_pc,
                             upd_taken ? upd_target : upd_pc + 32'd4);
                end
            end
            checks++;
            if (int'(br_count) !== m_br || int'(mp_count) !== m_mp) begin
                errors++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d",
                         n, br_count, mp_count, m_br, m_mp);
            end
            @(posedge clk);
            if (upd_valid) begin
                model_update(mode, upd_pc, upd_taken, upd_target,
                             upd_pred_taken);
            end
            #1;
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        mode = 2'b01;
        if_pc = 32'h100;
        upd_valid = 1'b1;
        upd_pc = 32'h100;
        upd_target = 32'h200;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b1;
        @(posedge clk);
        model_update(2'b01, 32'h100, 1'b1, 32'h200, 1'b1);
        #1;
        mode = 2'b00;
        upd_pc = 32'h44;
        upd_pred_taken = 1'b0;
        while (m_br < 65534) begin
            @(posedge clk);
            model_update(2'b00, 32'h44, 1'b1, 32'h200, 1'b0);
        end
        #1;
        checks++;
        if (br_count !== 16'hFFFE || mp_count !== 16'hFFFD) begin
            errors++;
            $display("FAIL near_sat: got %h/%h want FFFE/FFFD",
                     br_count, mp_count);
        end
        repeat (3) @(posedge clk);
        #1;
        upd_valid = 1'b0;
        mode = 2'b01;
        #1;
        checks++;
        if (br_count !== 16'hFFFF || mp_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: got %h/%h want FFFF/FFFF",
                     br_count, mp_count);
        end
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL pre_reset_hit: got %b/%h want 1/200",
                     pred_taken, pred_target);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (br_count !== 16'd0 || mp_count !== 16'd0 ||
            pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++;
            $display("FAIL async_reset: got br=%h mp=%h pt=%b tg=%h want 0/0/0/104",
                     br_count, mp_count, pred_taken, pred_target);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_cleared_valid: got pt=%b want 0", pred_taken);
        end
    endtask

    initial begin
        rst = 1'b0;
        mode = 2'b00;
        if_pc = '0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_target = '0;
        upd_taken = 1'b0;
        upd_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_train();
        test_loop();
        test_delay_slot();
        test_alias();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; power of two, 4..256.
REQ-002 Parameter PC_W, default 32, width of all PC and target buses.
REQ-003 Parameter CNT_INIT, default 2'b01, reset value of every 2-bit counter (weakly not-taken).
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 rst  input  1  asynchronous, active-low reset; state clears while low.
REQ-006 mode  input  2  strategy: 00 static not-taken, 01 static taken (BTB), 10 delay slot, 11 dynamic 2-bit.
REQ-007 if_pc  input  PC_W  fetch-stage PC to predict.
REQ-008 pred_taken  output  1  prediction for if_pc.
REQ-009 pred_target  output  PC_W  predicted next PC for if_pc.
REQ-010 upd_valid  input  1  resolved branch present in EX this cycle.
REQ-011 upd_pc, upd_target  input  PC_W each  resolved branch PC and actual target.
REQ-012 upd_taken  input  1  actual outcome.
REQ-013 upd_pred_taken  input  1  prediction that was made for this branch, carried down the pipe.
REQ-014 mispredict  output  1  resolved branch was mispredicted.
REQ-015 redirect_pc  output  PC_W  correct next PC when mispredict=1.
REQ-016 squash_ifid  output  1  kill the instruction in IF/ID.
REQ-017 br_count, mp_count  output  16 each  resolved-branch and mispredict statistics.

Function
REQ-018 Index = PC[log2(ENTRIES)+1:2]; tag = remaining upper PC bits above the index.
REQ-019 Each entry holds: valid (1), tag, target (PC_W), 2-bit saturating counter.
REQ-020 Lookup is combinational from if_pc; hit = valid && tag match.
REQ-021 mode 00 or 10: pred_taken=0.
REQ-022 mode 01: pred_taken=hit.
REQ-023 mode 11: pred_taken = hit && counter[1].
REQ-024 pred_target = stored target when pred_taken=1, else if_pc+4, modulo 2^PC_W.
REQ-025 Tables write on the rising edge when upd_valid=1; lookup in the same cycle returns pre-update contents (read-before-write, including same index).
REQ-026 Modes 01 and 11, upd_taken=1: write valid=1, tag, and target into the entry.
REQ-027 Mode 11, on tag hit: counter increments if taken (saturates at 11) and decrements if not (saturates at 00).
REQ-028 Mode 11, on allocation (miss, taken): counter is set to 2'b10.
REQ-029 Mode 11, miss and not taken: no entry write.
REQ-030 Modes 00 and 10: no table writes.
REQ-031 mispredict = upd_valid && (upd_taken != upd_pred_taken); combinational.
REQ-032 redirect_pc = upd_target if upd_taken, else upd_pc+4.
REQ-033 squash_ifid = mispredict, except in mode 10, where it is 0 (delay-slot instruction is kept).
REQ-034 br_count increments by 1 on every edge with upd_valid=1.
REQ-035 mp_count increments by 1 on every edge with mispredict=1.
REQ-036 Both counters saturate at 16'hFFFF.
REQ-037 A mode change takes effect on the next lookup; table contents are retained across mode changes.
REQ-038 When upd_valid=0, mispredict=0, squash_ifid=0, and redirect_pc is don't-care.

Reset
REQ-039 While rst=0: all valid bits=0, all counters=CNT_INIT, br_count=0, mp_count=0.
REQ-040 Outputs during reset: pred_taken=0, pred_target=if_pc+4.
REQ-041 An upd_valid asserted while rst=0 is ignored.
REQ-042 Reset asserted mid-operation clears state immediately, without waiting for clk.
REQ-043 The first edge after rst rises behaves as a normal update edge.

Verification
REQ-044 Reset, mode 11, if_pc=0x14 -> pred_taken=0, pred_target=0x18, br_count=0.
REQ-045 Mode 11, update pc=0x14, taken, target=0x54, pred_taken=0 -> mispredict=1, redirect_pc=0x54, squash_ifid=1; next cycle lookup 0x14 -> pred_taken=1, pred_target=0x54.
REQ-046 Mode 11, loop branch at 0x20: taken x4, then not-taken x1, then taken.
  - Counter sequence: 10, 11, 11, 11, 10, 11.
  - Exactly 2 mispredicts counted: the first allocation and the not-taken exit.
REQ-047 Mode 10, taken branch at 0x3C, target 0x10, pred 0 -> mispredict=1, squash_ifid=0, redirect_pc=0x10.
REQ-048 Aliasing, ENTRIES=16: train 0x14 taken, then look up 0x54 (same index, different tag) -> pred_taken=0; same-cycle update/lookup of 0x14 returns old entry.
REQ-049 Force br_count to 16'hFFFE, apply 3 updates -> br_count holds 16'hFFFF; assert rst mid-clock -> all counters 0 and pred_taken=0 before the next edge.
